imm_gen_stage: RTL and testbench
================================

// Module: imm_gen_stage
// PURPOSE
//  Registered, parametrised immediate generator for the decode stage: takes a 32-bit RV instruction, classifies its
//  format, and emits the sign-/zero-extended immediate at XLEN width. Covers all RV32I/RV64I immediate formats,
//  including shift-amount (shamt) immediates. Sits between fetch and the ALU/AGU operand mux, with valid/ready
//  handshakes on both sides, a 2-entry skid buffer for full throughput, and a synchronous flush for branch redirects.
// PARAMETERS
//  XLEN   32  datapath width; legal values 32 or 64
// PORTS
//  clk          in   1     rising-edge clock
//  rst_n        in   1     asynchronous active-low reset
//  flush        in   1     synchronous: discard all buffered entries
//  in_valid     in   1     in_inst is valid
//  in_ready     out  1     stage can accept; registered (= skid entry empty)
//  in_inst      in   32    instruction word
//  out_valid    out  1     out_* valid
//  out_ready    in   1     consumer accepts
//  out_imm      out  XLEN  extended immediate
//  out_fmt      out  3     format code (see package)
//  out_inst     out  32    instruction passed through, aligned with out_imm
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, out_imm=0, out_fmt=FMT_R, out_inst=0, skid empty, in_ready=1.
//  Decode by in_inst[6:0], S = in_inst[31]:
//   0010011 funct3 001/101 -> FMT_SH, imm = zero-ext shamt: inst[24:20] (XLEN=32) / inst[25:20] (XLEN=64)
//   0010011 other, 0000011, 1100111 -> FMT_I, {S..,inst[31:20]}
//   0100011 -> FMT_S, {S..,inst[31:25],inst[11:7]}
//   1100011 -> FMT_B, {S..,inst[31],inst[7],inst[30:25],inst[11:8],0}
//   1101111 -> FMT_J, {S..,inst[31],inst[19:12],inst[20],inst[30:21],0}
//   0110111, 0010111 -> FMT_U, {S..(XLEN-32 bits),inst[31:12],12'b0}
//   0110011 -> FMT_R, imm = 0
//   any other opcode -> FMT_ILL, imm = 0 (never X)
//  Latency: 1 cycle from in_valid&in_ready to out_valid. Throughput 1/cycle while out_ready=1.
//  Handshake: transfer on valid&ready. out_* held stable while out_valid&!out_ready.
//   Main register full & stalled & new input accepted -> input goes to skid entry; in_ready drops next cycle.
//   Skid full: in_ready=0. When out_ready, main <= skid, skid empties, in_ready=1 next cycle. Order preserved.
//   Simultaneous out pop and in push with skid empty -> main reloads directly, no bubble.
//  flush=1: next edge out_valid=0, skid empty, in_ready=1; any input handshaking in the flush cycle is discarded.
//   flush wins over every simultaneous push/pop.
//  Reset asserted mid-transfer: all entries dropped immediately, no partial output.
// STRUCTURE
//  Package imm_pkg: opcode localparams (OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI,
//   OP_AUIPC, OP_REG); fmt typedef: FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_SH=6, FMT_ILL=7.
//  Sub-module imm_decode (combinational, XLEN param): inst -> {imm, fmt}; instanced once at input side so the
//   skid and main entries store decoded results. imm_gen_stage holds the main/skid registers and handshake logic.
// TESTING
//  1 XLEN=32, inst 32'hFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=32'hFFFFFFFF, fmt=FMT_I.
//  2 inst 32'hFE112E23 (sw) -> imm=32'hFFFFFFFC, FMT_S; 32'hFE000EE3 (beq -4) -> imm=32'hFFFFFFFC, FMT_B;
//    32'h8000006F (jal) -> imm=32'hFFF00000, FMT_J.
//  3 XLEN=64: 32'h800000B7 (lui) -> imm=64'hFFFFFFFF80000000 FMT_U; 32'h03F09093 (slli 63) -> imm=63, FMT_SH.
//  4 opcode 7'b1111111 -> FMT_ILL, imm=0; opcode 0110011 -> FMT_R, imm=0; no X on any output.
//  5 stream of 4 insts, out_ready low 3 cycles: in_ready drops after 2 accepted, outputs stable; release ->
//    all 4 appear in order, no loss or duplication, throughput 1/cycle after release.
//  6 flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1; flushed insts never appear.

Source files
------------

// File: rtl/imm_gen_stage_pkg.sv
// Shared opcode constants and immediate format codes for the decode-stage immediate generator.
package imm_pkg;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_SH  = 3'd6,
      FMT_ILL = 3'd7
   } fmt_e;

   // funct3 values of OP_IMM that carry a shift amount rather than a 12-bit immediate
   function automatic logic is_shift(input logic [2:0] funct3);
      return (funct3 == 3'b001) || (funct3 == 3'b101);
   endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Fetch-side and operand-mux-side handshake bundle of the immediate generator stage.
interface imm_gen_stage_if
   import imm_pkg::*;
#(
   parameter int unsigned XLEN = 32
);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   fmt_e            out_fmt;
   logic [31:0]     out_inst;

   modport master (
      output in_valid, in_inst, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_inst
   );

   modport slave (
      input  in_valid, in_inst, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_inst
   );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: classifies the instruction format and extends
// its immediate to XLEN bits.
module imm_decode
   import imm_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     i_inst,
   output logic [XLEN-1:0] o_imm,
   output fmt_e            o_fmt
);

   logic [31:0] w_imm32;
   logic        w_sext;

   // Every format is a 32-bit value sign-extended to XLEN except the shift amount
   always_comb begin
      w_imm32 = '0;
      w_sext  = 1'b1;
      o_fmt   = FMT_ILL;
      case (i_inst[6:0])
         OP_IMM: begin
            if (is_shift(i_inst[14:12])) begin
               o_fmt  = FMT_SH;
               w_sext = 1'b0;
               w_imm32 = (XLEN == 64) ? {26'b0, i_inst[25:20]} : {27'b0, i_inst[24:20]};
            end else begin
               o_fmt   = FMT_I;
               w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            end
         end
         OP_LOAD, OP_JALR: begin
            o_fmt   = FMT_I;
            w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
         end
         OP_STORE: begin
            o_fmt   = FMT_S;
            w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         end
         OP_BRANCH: begin
            o_fmt   = FMT_B;
            w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
         end
         OP_JAL: begin
            o_fmt   = FMT_J;
            w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21],
                       1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            o_fmt   = FMT_U;
            w_imm32 = {i_inst[31:12], 12'b0};
         end
         OP_REG: begin
            o_fmt = FMT_R;
         end
         default: begin
            o_fmt = FMT_ILL;
         end
      endcase
      o_imm = w_sext ? XLEN'($signed(w_imm32)) : XLEN'(w_imm32);
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage: decodes at the input, then holds results in a main output
// register backed by a one-entry skid register so fetch never sees a combinational ready path.
module imm_gen_stage
   import imm_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input logic            clk,
   input logic            rst_n,
   input logic            flush,
   imm_gen_stage_if.slave bus
);

   logic [XLEN-1:0] w_dec_imm;
   fmt_e            w_dec_fmt;
   logic            w_push;
   logic            w_pop;

   logic            r_main_valid;
   logic [XLEN-1:0] r_main_imm;
   fmt_e            r_main_fmt;
   logic [31:0]     r_main_inst;
   logic            r_skid_valid;
   logic [XLEN-1:0] r_skid_imm;
   fmt_e            r_skid_fmt;
   logic [31:0]     r_skid_inst;

   imm_decode #(
      .XLEN (XLEN)
   ) u_decode (
      .i_inst (bus.in_inst),
      .o_imm  (w_dec_imm),
      .o_fmt  (w_dec_fmt)
   );

   assign w_push = bus.in_valid & ~r_skid_valid;
   assign w_pop  = r_main_valid & bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_main_imm   <= '0;
         r_main_fmt   <= FMT_R;
         r_main_inst  <= '0;
         r_skid_valid <= 1'b0;
         r_skid_imm   <= '0;
         r_skid_fmt   <= FMT_R;
         r_skid_inst  <= '0;
      end else if (flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (r_skid_valid) begin
         // in_ready is low here, so only a pop can move state
         if (w_pop) begin
            r_main_imm   <= r_skid_imm;
            r_main_fmt   <= r_skid_fmt;
            r_main_inst  <= r_skid_inst;
            r_skid_valid <= 1'b0;
         end
      end else if (w_push) begin
         if (!r_main_valid || w_pop) begin
            r_main_valid <= 1'b1;
            r_main_imm   <= w_dec_imm;
            r_main_fmt   <= w_dec_fmt;
            r_main_inst  <= bus.in_inst;
         end else begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_dec_imm;
            r_skid_fmt   <= w_dec_fmt;
            r_skid_inst  <= bus.in_inst;
         end
      end else if (w_pop) begin
         r_main_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = ~r_skid_valid;
   assign bus.out_valid = r_main_valid;
   assign bus.out_imm   = r_main_imm;
   assign bus.out_fmt   = r_main_fmt;
   assign bus.out_inst  = r_main_inst;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: drives XLEN=32 and XLEN=64 instances with one stimulus stream and checks
// both against an arithmetic immediate model and a two-deep queue scoreboard.
module tb_imm_gen_stage;
   import imm_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_inst;
   logic        out_ready;

   int total;
   int bad;
   logic [31:0] q[$];

   imm_gen_stage_if #(.XLEN(32)) bus32 ();
   imm_gen_stage_if #(.XLEN(64)) bus64 ();

   assign bus32.in_valid  = in_valid;
   assign bus32.in_inst   = in_inst;
   assign bus32.out_ready = out_ready;
   assign bus64.in_valid  = in_valid;
   assign bus64.in_inst   = in_inst;
   assign bus64.out_ready = out_ready;

   imm_gen_stage #(.XLEN(32)) u_dut32 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus32)
   );

   imm_gen_stage #(.XLEN(64)) u_dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Immediate value computed as a signed integer from field weights
   function automatic void ref_imm(input logic [31:0] inst, input bit is64,
                                   output logic [63:0] imm, output fmt_e fmt);
      int     s;
      longint v;
      longint top;
      int     u;
      s   = int'(inst);
      top = longint'(s) >>> 31;
      v   = 0;
      fmt = FMT_ILL;
      case (inst[6:0])
         OP_IMM: begin
            if (inst[14:12] == 3'b001 || inst[14:12] == 3'b101) begin
               fmt = FMT_SH;
               v   = is64 ? longint'(inst[25:20]) : longint'(inst[24:20]);
            end else begin
               fmt = FMT_I;
               v   = longint'(s) >>> 20;
            end
         end
         OP_LOAD, OP_JALR: begin
            fmt = FMT_I;
            v   = longint'(s) >>> 20;
         end
         OP_STORE: begin
            fmt = FMT_S;
            v   = (longint'(s) >>> 25) * 32 + longint'(inst[11:7]);
         end
         OP_BRANCH: begin
            fmt = FMT_B;
            v   = top * 4096 + longint'(inst[7]) * 2048 + longint'(inst[30:25]) * 32
                + longint'(inst[11:8]) * 2;
         end
         OP_JAL: begin
            fmt = FMT_J;
            v   = top * 1048576 + longint'(inst[19:12]) * 4096 + longint'(inst[20]) * 2048
                + longint'(inst[30:21]) * 2;
         end
         OP_LUI, OP_AUIPC: begin
            fmt = FMT_U;
            u   = int'(inst & 32'hFFFF_F000);
            v   = longint'(u);
         end
         OP_REG: begin
            fmt = FMT_R;
            v   = 0;
         end
         default: begin
            fmt = FMT_ILL;
            v   = 0;
         end
      endcase
      imm = is64 ? 64'(v) : {32'b0, v[31:0]};
   endfunction

   // One clock: check outputs at the falling edge, advance the scoreboard, return at posedge+1
   task automatic tick(output bit acc, output bit pop);
      logic [63:0] e_imm;
      fmt_e        e_fmt;
      @(negedge clk);
      chk("ov32", 64'(bus32.out_valid), 64'(q.size() > 0));
      chk("ov64", 64'(bus64.out_valid), 64'(q.size() > 0));
      chk("ir32", 64'(bus32.in_ready), 64'(q.size() < 2));
      chk("ir64", 64'(bus64.in_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
         ref_imm(q[0], 1'b0, e_imm, e_fmt);
         chk("imm32", 64'(bus32.out_imm), e_imm);
         chk("fmt32", 64'(bus32.out_fmt), 64'(e_fmt));
         chk("inst32", 64'(bus32.out_inst), 64'(q[0]));
         ref_imm(q[0], 1'b1, e_imm, e_fmt);
         chk("imm64", bus64.out_imm, e_imm);
         chk("fmt64", 64'(bus64.out_fmt), 64'(e_fmt));
         chk("inst64", 64'(bus64.out_inst), 64'(q[0]));
      end
      acc = in_valid && (q.size() < 2) && !flush;
      pop = out_ready && (q.size() > 0) && !flush;
      if (flush) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(in_inst);
      end
      @(posedge clk);
      #1;
   endtask

   logic [31:0] d_inst [8];
   logic [31:0] d_e32  [8];
   logic [63:0] d_e64  [8];
   fmt_e        d_fmt  [8];
   logic [6:0]  ops    [10];

   initial begin
      bit          a;
      bit          p;
      int          idx;
      int          pops;
      logic [31:0] s [4];
      logic [31:0] r;

      d_inst[0] = 32'hFFF00093; d_e32[0] = 32'hFFFFFFFF; d_e64[0] = 64'hFFFFFFFFFFFFFFFF;
      d_fmt[0] = FMT_I;
      d_inst[1] = 32'hFE112E23; d_e32[1] = 32'hFFFFFFFC; d_e64[1] = 64'hFFFFFFFFFFFFFFFC;
      d_fmt[1] = FMT_S;
      d_inst[2] = 32'hFE000EE3; d_e32[2] = 32'hFFFFFFFC; d_e64[2] = 64'hFFFFFFFFFFFFFFFC;
      d_fmt[2] = FMT_B;
      d_inst[3] = 32'h8000006F; d_e32[3] = 32'hFFF00000; d_e64[3] = 64'hFFFFFFFFFFF00000;
      d_fmt[3] = FMT_J;
      d_inst[4] = 32'h800000B7; d_e32[4] = 32'h80000000; d_e64[4] = 64'hFFFFFFFF80000000;
      d_fmt[4] = FMT_U;
      d_inst[5] = 32'h03F09093; d_e32[5] = 32'd31;       d_e64[5] = 64'd63;
      d_fmt[5] = FMT_SH;
      d_inst[6] = 32'hFFFFFFFF; d_e32[6] = 32'h0;        d_e64[6] = 64'h0;
      d_fmt[6] = FMT_ILL;
      d_inst[7] = 32'h002081B3; d_e32[7] = 32'h0;        d_e64[7] = 64'h0;
      d_fmt[7] = FMT_R;
      ops = '{OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC, OP_REG,
              7'b1111111};

      total = 0;
      bad = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      in_inst = '0;
      out_ready = 1'b0;

      @(negedge clk);
      chk("rst_ov32", 64'(bus32.out_valid), 64'd0);
      chk("rst_ir32", 64'(bus32.in_ready), 64'd1);
      chk("rst_imm32", 64'(bus32.out_imm), 64'd0);
      chk("rst_fmt32", 64'(bus32.out_fmt), 64'(FMT_R));
      chk("rst_inst32", 64'(bus32.out_inst), 64'd0);
      chk("rst_imm64", bus64.out_imm, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Directed vectors with fixed expected immediates, streamed back to back
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_inst  = d_inst[i];
         tick(a, p);
         chk("dir_acc", 64'(a), 64'd1);
         chk("dir_imm32", 64'(bus32.out_imm), 64'(d_e32[i]));
         chk("dir_imm64", bus64.out_imm, d_e64[i]);
         chk("dir_fmt32", 64'(bus32.out_fmt), 64'(d_fmt[i]));
         chk("dir_fmt64", 64'(bus64.out_fmt), 64'(d_fmt[i]));
      end
      in_valid = 1'b0;
      tick(a, p);
      tick(a, p);

      // Four-instruction stream against a three-cycle consumer stall
      s = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
      idx = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = (idx < 4);
         in_inst  = (idx < 4) ? s[idx] : 32'h0;
         tick(a, p);
         if (a) idx++;
      end
      chk("stall_accepted", 64'(idx), 64'd2);
      chk("stall_ir", 64'(bus32.in_ready), 64'd0);
      out_ready = 1'b1;
      pops = 0;
      for (int i = 0; i < 4; i++) begin
         in_valid = (idx < 4);
         in_inst  = (idx < 4) ? s[idx] : 32'h0;
         tick(a, p);
         if (a) idx++;
         if (p) pops++;
      end
      chk("release_pops", 64'(pops), 64'd4);
      chk("release_accepted", 64'(idx), 64'd4);
      in_valid = 1'b0;
      tick(a, p);

      // Flush with both entries occupied and a new input presented
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_inst = 32'h00500293;
      tick(a, p);
      in_inst = 32'h00600313;
      tick(a, p);
      flush = 1'b1;
      in_inst = 32'h00700393;
      out_ready = 1'b1;
      tick(a, p);
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_ov", 64'(bus32.out_valid), 64'd0);
      chk("flush_ir", 64'(bus64.in_ready), 64'd1);
      for (int i = 0; i < 3; i++) tick(a, p);

      // Asynchronous reset while both entries are full
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_inst = 32'hFFC00413;
      tick(a, p);
      in_inst = 32'h01400493;
      tick(a, p);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ov32", 64'(bus32.out_valid), 64'd0);
      chk("arst_ov64", 64'(bus64.out_valid), 64'd0);
      chk("arst_ir32", 64'(bus32.in_ready), 64'd1);
      chk("arst_inst", 64'(bus64.out_inst), 64'd0);
      q.delete();
      tick(a, p);
      rst_n = 1'b1;

      // Randomized traffic with occasional flushes
      for (int i = 0; i < 600; i++) begin
         r = $urandom();
         in_inst   = {r[31:7], ops[$urandom_range(0, 9)]};
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         tick(a, p);
      end
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) tick(a, p);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
